// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, frame width and receiver FSM states.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_,
  output logic tick
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  // A divide-by-one still needs a 1-bit counter to keep the widths legal.
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and framing-error detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_BITS - 1);

  logic                 sample_tick;
  logic                 rx_meta;
  logic                 rx_sync;
  uart_state_t          state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk  (clk),
    .rst_ (rst_),
    .tick (sample_tick)
  );

  // Flops reset to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  // Start bit is checked at its middle; every later bit is sampled 16 ticks on.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            tick_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (sample_tick) begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              if (!rx_sync) begin
                bit_idx <= '0;
                state   <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt           <= '0;
              shift_reg[bit_idx] <= rx_sync;
              if (bit_idx == LAST_BIT) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (sample_tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (rx_sync) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                state    <= IDLE;
              end else begin
                rx_error <= 1'b1;
                state    <= WAIT_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        // A held-low line (break) must return high before a new frame can start.
        WAIT_IDLE: begin
          if (rx_sync) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table of single frames plus hand-written corner sequences.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 434;

  logic       clk = 1'b0;
  logic       rst_;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  always #10 clk = ~clk;

  uart_rx #(
    .CLK_FREQ  (50_000_000),
    .BAUD_RATE (115200)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_valid;
    int         exp_error;
    logic [7:0] exp_data;
  } vec_t;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int start_cyc = 0;
  int data_cyc = 0;
  logic [7:0] got_q[$];

  // Pulse and state monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got_q.push_back(rx_data);
    end
    if (rx_error) err_cnt++;
    if (rx_valid && rx_error) both_cnt++;
    if (dut.state == START) start_cyc++;
    if (dut.state == DATA) data_cyc++;
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
    rx_serial = 1'b1;
  endtask

  initial begin
    vec_t vecs[4];
    logic [7:0] exp_q[$];
    int v0, e0, s0, base, gap;

    vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_valid: 1, exp_error: 0, exp_data: 8'hA5};
    vecs[1] = '{data: 8'h5A, stop_bit: 1'b0, exp_valid: 0, exp_error: 1, exp_data: 8'hA5};
    vecs[2] = '{data: 8'h81, stop_bit: 1'b1, exp_valid: 1, exp_error: 0, exp_data: 8'h81};
    vecs[3] = '{data: 8'h7E, stop_bit: 1'b0, exp_valid: 0, exp_error: 1, exp_data: 8'h81};

    rst_      = 1'b0;
    rx_serial = 1'b0;
    idle(5);
    check_output("reset_rx_data", int'(rx_data), 0);
    check_output("reset_rx_valid", int'(rx_valid), 0);
    check_output("reset_rx_error", int'(rx_error), 0);
    check_output("reset_state", int'(dut.state), int'(IDLE));

    // Line held low from reset release: looks like a frame of zeros with a bad stop bit.
    rst_ = 1'b1;
    for (int c = 0; c < 6000 && err_cnt == 0; c++) @(negedge clk);
    check_output("hold0_error_once", err_cnt, 1);
    check_output("hold0_no_valid", valid_cnt, 0);
    check_output("hold0_saw_start", int'(start_cyc > 0), 1);
    check_output("hold0_saw_data", int'(data_cyc > 0), 1);
    idle(1000);
    check_output("hold0_wait_idle", int'(dut.state), int'(WAIT_IDLE));
    check_output("hold0_no_second_error", err_cnt, 1);
    check_output("hold0_rx_data_kept", int'(rx_data), 0);
    rx_serial = 1'b1;
    idle(10);
    check_output("hold0_back_to_idle", int'(dut.state), int'(IDLE));
    idle(200);

    gap = 0;
    for (int c = 0; c < 100 && !dut.sample_tick; c++) @(negedge clk);
    do begin
      @(negedge clk);
      gap++;
    end while (!dut.sample_tick && gap < 100);
    check_output("tick_period", gap, 27);

    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      apply_stimulus(vecs[i].data, vecs[i].stop_bit);
      idle(500);
      check_output($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      check_output($sformatf("vec%0d_error", i), err_cnt - e0, vecs[i].exp_error);
      check_output($sformatf("vec%0d_data", i), int'(rx_data), int'(vecs[i].exp_data));
    end

    // Three frames with the next start bit right after each stop bit.
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    base  = got_q.size();
    v0    = valid_cnt;
    e0    = err_cnt;
    foreach (exp_q[i]) apply_stimulus(exp_q[i], 1'b1);
    idle(500);
    check_output("b2b_valid_count", valid_cnt - v0, 3);
    check_output("b2b_error_count", err_cnt - e0, 0);
    for (int i = 0; i < 3; i++) begin
      if (base + i < got_q.size())
        check_output($sformatf("b2b_data%0d", i), int'(got_q[base + i]), int'(exp_q[i]));
      else
        check_output($sformatf("b2b_data%0d_missing", i), -1, int'(exp_q[i]));
    end

    s0 = start_cyc;
    v0 = valid_cnt;
    e0 = err_cnt;
    rx_serial = 1'b0;
    idle(100);
    rx_serial = 1'b1;
    idle(600);
    check_output("glitch_no_valid", valid_cnt - v0, 0);
    check_output("glitch_no_error", err_cnt - e0, 0);
    check_output("glitch_saw_start", int'(start_cyc > s0), 1);
    check_output("glitch_state_idle", int'(dut.state), int'(IDLE));
    check_output("glitch_data_kept", int'(rx_data), 8'h3C);

    // Reset in the middle of a byte, away from any clock edge.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx_serial = 1'b0;
    idle(200);
    #3 rst_ = 1'b0;
    #1;
    check_output("midreset_rx_data", int'(rx_data), 0);
    check_output("midreset_rx_valid", int'(rx_valid), 0);
    check_output("midreset_rx_error", int'(rx_error), 0);
    check_output("midreset_state", int'(dut.state), int'(IDLE));
    rx_serial = 1'b1;
    idle(20);
    rst_ = 1'b1;
    idle(500);
    check_output("midreset_no_pulse_valid", valid_cnt - v0, 0);
    check_output("midreset_no_pulse_error", err_cnt - e0, 0);
    v0 = valid_cnt;
    e0 = err_cnt;
    apply_stimulus(8'hC3, 1'b1);
    idle(500);
    check_output("after_reset_valid", valid_cnt - v0, 1);
    check_output("after_reset_error", err_cnt - e0, 0);
    check_output("after_reset_data", int'(rx_data), 8'hC3);

    check_output("never_valid_and_error", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
